// File: rtl/bhand_fifo.sv
// Ring-buffer FIFO with registered vld/rdy flags on both sides and an almost-full flag.
// Define BHAND_FIFO_COUNT_EN to expose the internal occupancy on the count port.
module bhand_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_LOG2   = 2,
  parameter int AFULL_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  idata_vld,
  output logic                  idata_rdy,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  odata_vld,
  input  logic                  odata_rdy,
`ifdef BHAND_FIFO_COUNT_EN
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count
`else
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_AFULL = CW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         occ_next;
  logic                  push;
  logic                  pop;

  assign push = idata_vld & idata_rdy;
  assign pop  = odata_vld & odata_rdy;

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + CNT_ONE;
      2'b01:   occ_next = occ - CNT_ONE;
      default: occ_next = occ;
    endcase
  end

  // Flags are registered from occ_next so neither side sees a combinational path from the other.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      idata_rdy   <= 1'b0;
      odata_vld   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      occ         <= occ_next;
      idata_rdy   <= (occ_next != CNT_FULL);
      odata_vld   <= (occ_next != '0);
      almost_full <= (occ_next >= CNT_AFULL);
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= idata;
  end

  assign odata = mem[rd_ptr];

`ifdef BHAND_FIFO_COUNT_EN
  assign count = occ;
`endif

endmodule

// File: tb/tb_bhand_fifo.sv
// Self-checking bench for bhand_fifo: directed scenarios plus a randomised run against a queue model.
// Builds with or without BHAND_FIFO_COUNT_EN; count checks only exist when the port does.
module tb_bhand_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] idata = 8'h00;
  logic       idata_vld = 1'b0;
  logic       idata_rdy;
  logic [7:0] odata;
  logic       odata_vld;
  logic       odata_rdy = 1'b0;
  logic       almost_full;
`ifdef BHAND_FIFO_COUNT_EN
  logic [2:0] count;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: a queue plus the flags it implies after each edge.
  logic [7:0] q [$];
  logic       m_rdy = 1'b0;
  logic       m_vld = 1'b0;
  logic       m_af  = 1'b0;
  logic       last_push = 1'b0;
  logic       last_pop  = 1'b0;

  bhand_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .AFULL_THRESH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .idata      (idata),
    .idata_vld  (idata_vld),
    .idata_rdy  (idata_rdy),
    .odata      (odata),
    .odata_vld  (odata_vld),
    .odata_rdy  (odata_rdy),
`ifdef BHAND_FIFO_COUNT_EN
    .almost_full(almost_full),
    .count      (count)
`else
    .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    last_push = !rst && idata_vld && m_rdy;
    last_pop  = !rst && odata_rdy && m_vld;
    if (rst) begin
      q.delete();
    end else begin
      if (last_pop)  void'(q.pop_front());
      if (last_push) q.push_back(idata);
    end
    m_rdy = !rst && (q.size() != 4);
    m_vld = (q.size() != 0);
    m_af  = (q.size() >= 3);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (idata_rdy !== 1'b0) begin fails++; $display("[TB] FAIL reset_rdy: got %b expected 0", idata_rdy); end
    tests++; if (odata_vld !== 1'b0) begin fails++; $display("[TB] FAIL reset_vld: got %b expected 0", odata_vld); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("[TB] FAIL reset_af: got %b expected 0", almost_full); end
    rst = 1'b0;
    tick();
    tests++; if (idata_rdy !== 1'b1) begin fails++; $display("[TB] FAIL rdy_after_reset: got %b expected 1", idata_rdy); end
`ifdef BHAND_FIFO_COUNT_EN
    tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_single();
    odata_rdy = 1'b0;
    idata = 8'h11; idata_vld = 1'b1;
    tick();
    idata_vld = 1'b0;
    tests++; if (odata_vld !== 1'b1) begin fails++; $display("[TB] FAIL single_vld: got %b expected 1", odata_vld); end
    tests++; if (odata !== 8'h11) begin fails++; $display("[TB] FAIL single_data: got %h expected 11", odata); end
    tests++; if (idata_rdy !== 1'b1) begin fails++; $display("[TB] FAIL single_rdy: got %b expected 1", idata_rdy); end
    odata_rdy = 1'b1;
    tick();
    odata_rdy = 1'b0;
    tests++; if (odata_vld !== 1'b0) begin fails++; $display("[TB] FAIL single_drained: got %b expected 0", odata_vld); end
  endtask

  task automatic test_fill();
    logic [7:0] word;
    odata_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word = 8'hA0 + 8'(i);
      idata = word; idata_vld = 1'b1;
      tick();
      tests++; if (almost_full !== (i >= 2)) begin fails++; $display("[TB] FAIL fill_af_%0d: got %b expected %b", i, almost_full, (i >= 2)); end
      tests++; if (idata_rdy !== (i < 3)) begin fails++; $display("[TB] FAIL fill_rdy_%0d: got %b expected %b", i, idata_rdy, (i < 3)); end
    end
`ifdef BHAND_FIFO_COUNT_EN
    tests++; if (count !== 3'd4) begin fails++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
`endif
    idata = 8'hA4; idata_vld = 1'b1;
    tick();
    tests++; if (idata_rdy !== 1'b0) begin fails++; $display("[TB] FAIL full_hold_rdy: got %b expected 0", idata_rdy); end
    tests++; if (odata !== 8'hA0) begin fails++; $display("[TB] FAIL full_head: got %h expected a0", odata); end
  endtask

  task automatic test_full_drain();
    logic [7:0] word;
    odata_rdy = 1'b1;
    tick();
    odata_rdy = 1'b0;
    tests++; if (idata_rdy !== 1'b1) begin fails++; $display("[TB] FAIL drain_rdy_back: got %b expected 1", idata_rdy); end
    tests++; if (odata !== 8'hA1) begin fails++; $display("[TB] FAIL drain_after_pop: got %h expected a1", odata); end
    tick();
    idata_vld = 1'b0;
    tests++; if (idata_rdy !== 1'b0) begin fails++; $display("[TB] FAIL drain_refull: got %b expected 0", idata_rdy); end
    odata_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word = 8'hA1 + 8'(i);
      tests++; if (odata_vld !== 1'b1 || odata !== word) begin fails++; $display("[TB] FAIL drain_word_%0d: got %b/%h expected 1/%h", i, odata_vld, odata, word); end
      tick();
    end
    odata_rdy = 1'b0;
    tests++; if (odata_vld !== 1'b0) begin fails++; $display("[TB] FAIL drain_empty: got %b expected 0", odata_vld); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] word;
    odata_rdy = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      if (t >= 1) begin
        word = 8'(t - 1);
        tests++; if (odata_vld !== 1'b1 || odata !== word) begin fails++; $display("[TB] FAIL stream_%0d: got %b/%h expected 1/%h", t, odata_vld, odata, word); end
        tests++; if (idata_rdy !== 1'b1) begin fails++; $display("[TB] FAIL stream_rdy_%0d: got %b expected 1", t, idata_rdy); end
`ifdef BHAND_FIFO_COUNT_EN
        tests++; if (count !== 3'd1) begin fails++; $display("[TB] FAIL stream_count_%0d: got %0d expected 1", t, count); end
`endif
      end
      idata = 8'(t);
      idata_vld = (t < 16);
      tick();
    end
    odata_rdy = 1'b0;
    tests++; if (odata_vld !== 1'b0) begin fails++; $display("[TB] FAIL stream_end: got %b expected 0", odata_vld); end
  endtask

  task automatic test_reset_mid();
    odata_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idata = 8'hC0 + 8'(i); idata_vld = 1'b1;
      tick();
    end
    rst = 1'b1; idata = 8'hEE;
    tick();
    rst = 1'b0;
    tests++; if (odata_vld !== 1'b0) begin fails++; $display("[TB] FAIL midrst_vld: got %b expected 0", odata_vld); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("[TB] FAIL midrst_af: got %b expected 0", almost_full); end
`ifdef BHAND_FIFO_COUNT_EN
    tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL midrst_count: got %0d expected 0", count); end
`endif
    idata = 8'h5A;
    tick();
    tick();
    idata_vld = 1'b0;
    tests++; if (odata_vld !== 1'b1 || odata !== 8'h5A) begin fails++; $display("[TB] FAIL midrst_first: got %b/%h expected 1/5a", odata_vld, odata); end
    odata_rdy = 1'b1;
    tick();
    odata_rdy = 1'b0;
    tests++; if (odata_vld !== 1'b0) begin fails++; $display("[TB] FAIL midrst_single: got %b expected 0", odata_vld); end
  endtask

  task automatic test_random();
    int sent = 0;
    int popped = 0;
    int cycles = 0;
    idata_vld = 1'b0;
    while (popped < 500 && cycles < 20000) begin
      if (!(idata_vld && !last_push)) begin
        idata_vld = (sent < 500) && ($urandom_range(0, 3) != 0);
        idata = 8'($urandom);
      end
      odata_rdy = ($urandom_range(0, 2) != 0);
      tests++; if (idata_rdy !== m_rdy) begin fails++; $display("[TB] FAIL rand_rdy@%0d: got %b expected %b", cycles, idata_rdy, m_rdy); end
      tests++; if (odata_vld !== m_vld) begin fails++; $display("[TB] FAIL rand_vld@%0d: got %b expected %b", cycles, odata_vld, m_vld); end
      tests++; if (almost_full !== m_af) begin fails++; $display("[TB] FAIL rand_af@%0d: got %b expected %b", cycles, almost_full, m_af); end
      if (m_vld) begin
        tests++; if (odata !== q[0]) begin fails++; $display("[TB] FAIL rand_data@%0d: got %h expected %h", cycles, odata, q[0]); end
      end
`ifdef BHAND_FIFO_COUNT_EN
      tests++; if (32'(count) != q.size() || count > 3'd4) begin fails++; $display("[TB] FAIL rand_count@%0d: got %0d expected %0d", cycles, count, q.size()); end
`endif
      tick();
      if (last_push) sent++;
      if (last_pop)  popped++;
      cycles++;
    end
    idata_vld = 1'b0;
    odata_rdy = 1'b0;
    tests++; if (popped != 500) begin fails++; $display("[TB] FAIL rand_budget: got %0d words expected 500", popped); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_drain();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
